// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and 7-segment decode for the keypad entry path.
// Pure definitions: no latency, no flow control.
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'd10;
   localparam logic [3:0] KEY_HASH = 4'd11;
   localparam logic [3:0] KEY_NONE = 4'hF;

   typedef enum logic [1:0] {IDLE, DEB, PRESS, HELD} state_t;

   // Common-anode {abcdefg}, 0 = lit; anything unmapped is blank.
   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         4'd10:   s = 7'b1110010;
         4'd11:   s = 7'b1100110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scan: free-running divider, one column per tick, sweep result registered 1 cycle after the col3 sample.
// No backpressure: sweep_done is a single-cycle pulse the consumer must take when it appears.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic       fin,
   input  logic       rst_n,
   input  logic [3:0] touch_key,
   output logic [2:0] scan_key,
   output logic       tick,
   output logic       refresh,
   output logic       sweep_done,
   output logic [3:0] sweep_key
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       scan_q, scan_d;
   logic [3:0]       row1_q, row1_d, row2_q, row2_d;
   logic             done_q, done_d;
   logic [3:0]       key_q, key_d;
   logic [3:0]       sweep;

   // rows[3] is row1; row4 holds the non-digit keys and 0.
   function automatic logic [3:0] col_key(input logic [3:0] col, input logic [3:0] rows);
      logic [3:0] k;
      case (rows)
         4'b1000: k = col + 4'd1;
         4'b0100: k = col + 4'd4;
         4'b0010: k = col + 4'd7;
         4'b0001: k = (col == 4'd0) ? KEY_STAR : (col == 4'd1) ? 4'd0 : KEY_HASH;
         default: k = KEY_NONE;
      endcase
      return k;
   endfunction

   assign tick = &div_q;

   if (DIV_W > 2) begin : g_refresh
      assign refresh = &div_q[DIV_W-3:0];
   end else begin : g_refresh_every
      assign refresh = 1'b1;
   end

   always_comb begin
      case ({|row1_q, |row2_q, |touch_key})
         3'b100:  sweep = col_key(4'd0, row1_q);
         3'b010:  sweep = col_key(4'd1, row2_q);
         3'b001:  sweep = col_key(4'd2, touch_key);
         default: sweep = KEY_NONE;
      endcase
   end

   always_comb begin
      div_d  = div_q + 1'b1;
      scan_d = scan_q;
      row1_d = row1_q;
      row2_d = row2_q;
      done_d = 1'b0;
      key_d  = key_q;
      case (scan_q)
         3'b100: if (tick) begin row1_d = touch_key; scan_d = 3'b010; end
         3'b010: if (tick) begin row2_d = touch_key; scan_d = 3'b001; end
         3'b001: if (tick) begin done_d = 1'b1; key_d = sweep; scan_d = 3'b100; end
         default: begin
            scan_d = 3'b100;
            row1_d = '0;
            row2_d = '0;
         end
      endcase
   end

   always_ff @(posedge fin or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         scan_q <= 3'b100;
         row1_q <= '0;
         row2_q <= '0;
         done_q <= 1'b0;
         key_q  <= KEY_NONE;
      end else begin
         div_q  <= div_d;
         scan_q <= scan_d;
         row1_q <= row1_d;
         row2_q <= row2_d;
         done_q <= done_d;
         key_q  <= key_d;
      end
   end

   assign scan_key   = scan_q;
   assign sweep_done = done_q;
   assign sweep_key  = key_q;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry: debounce per sweep, 4-digit entry buffer, committed code with valid/ack, muxed display.
// Event ~2 cycles after the final sweep; code_valid holds until code_ack, new entries ignored meanwhile.
module keypad_entry_ctrl
   import keypad_pkg::*;
#(
   parameter int DIV_W = 16,
   parameter int DEB_N = 3,
   parameter int NDIG  = 4
) (
   input  logic              fin,
   input  logic              rst_n,
   input  logic [3:0]        touch_key,
   output logic [2:0]        scan_key,
   output logic [6:0]        seg_S,
   output logic [NDIG-1:0]   digit_sel,
   output logic [4*NDIG-1:0] code,
   output logic              code_valid,
   input  logic              code_ack
);

   localparam int CW    = 4 * NDIG;
   localparam int CNT_W = $clog2(NDIG + 1);
   localparam int DEB_W = $clog2(DEB_N + 1);
   localparam int POS_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] NDIG_C   = CNT_W'(NDIG);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(NDIG - 1);

   logic             tick, refresh, sweep_done, ev;
   logic [3:0]       sweep_key, dig;
   state_t           state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [DEB_W-1:0] n_q, n_d;
   logic [CW-1:0]    entry_q, entry_d, code_q, code_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [NDIG-1:0]  sel_q, sel_d;
   logic [6:0]       seg_q, seg_d;

   keypad_scanner #(.DIV_W(DIV_W)) u_scanner (
      .fin        (fin),
      .rst_n      (rst_n),
      .touch_key  (touch_key),
      .scan_key   (scan_key),
      .tick       (tick),
      .refresh    (refresh),
      .sweep_done (sweep_done),
      .sweep_key  (sweep_key)
   );

   // n counts matching sweeps in DEB and consecutive empty sweeps in HELD.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      n_d     = n_q;
      ev      = 1'b0;
      case (state_q)
         IDLE: if (sweep_done && sweep_key != KEY_NONE) begin
            state_d = DEB;
            cand_d  = sweep_key;
            n_d     = DEB_W'(1);
         end
         DEB: if (sweep_done) begin
            if (sweep_key == KEY_NONE) begin
               state_d = IDLE;
            end else if (sweep_key == cand_q) begin
               n_d = n_q + 1'b1;
               if (n_q == DEB_LAST) state_d = PRESS;
            end else begin
               cand_d = sweep_key;
               n_d    = DEB_W'(1);
            end
         end
         PRESS: begin
            ev      = 1'b1;
            state_d = HELD;
            n_d     = '0;
         end
         HELD: if (sweep_done) begin
            if (sweep_key != KEY_NONE) begin
               n_d = '0;
            end else begin
               n_d = n_q + 1'b1;
               if (n_q == DEB_LAST) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // While a code is pending every key is ignored, so commit and ack never overlap.
   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = valid_q;
      if (valid_q) begin
         if (code_ack) begin
            valid_d = 1'b0;
            entry_d = '0;
            cnt_d   = '0;
         end
      end else if (ev) begin
         if (cand_q <= 4'd9) begin
            if (cnt_q < NDIG_C) begin
               entry_d = {entry_q[CW-5:0], cand_q};
               cnt_d   = cnt_q + 1'b1;
            end
         end else if (cand_q == KEY_STAR) begin
            entry_d = '0;
            cnt_d   = '0;
         end else if (cand_q == KEY_HASH && cnt_q == NDIG_C) begin
            code_d  = entry_q;
            valid_d = 1'b1;
         end
      end
   end

   // Each scan tick restarts the frame at the rightmost digit, locking the digit phase to the divider.
   always_comb begin
      pos_d = pos_q;
      if (tick)         pos_d = '0;
      else if (refresh) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      sel_d = ~(NDIG'(1) << pos_d);
      if (valid_q)                     dig = code_q[4*pos_d +: 4];
      else if (CNT_W'(pos_d) < cnt_q)  dig = entry_q[4*pos_d +: 4];
      else                             dig = KEY_NONE;
      seg_d = seg_decode(dig);
   end

   always_ff @(posedge fin or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= KEY_NONE;
         n_q     <= '0;
         entry_q <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         pos_q   <= '0;
         sel_q   <= ~NDIG'(1);
         seg_q   <= 7'b1111111;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         n_q     <= n_d;
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         pos_q   <= pos_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
      end
   end

   assign code       = code_q;
   assign code_valid = valid_q;
   assign digit_sel  = sel_q;
   assign seg_S      = seg_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: a keypad matrix model driven by scan_key, displays read back per digit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_keypad_entry_ctrl;

   localparam logic [6:0] S1 = 7'b1001111;
   localparam logic [6:0] S2 = 7'b0010010;
   localparam logic [6:0] S3 = 7'b0000110;
   localparam logic [6:0] S4 = 7'b1001100;
   localparam logic [6:0] S5 = 7'b0100100;
   localparam logic [6:0] S9 = 7'b0000100;
   localparam logic [6:0] SB = 7'b1111111;

   logic        fin = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  touch_key;
   logic [2:0]  scan_key;
   logic [6:0]  seg_S;
   logic [3:0]  digit_sel;
   logic [15:0] code;
   logic        code_valid;
   logic        code_ack = 1'b0;
   logic [11:0] kp = '0;   // bit col*4+row, row 0 = row1
   int          n_chk = 0;
   int          n_pass = 0;

   always #5 fin = ~fin;

   keypad_entry_ctrl #(.DIV_W(2), .DEB_N(3), .NDIG(4)) dut (
      .fin        (fin),
      .rst_n      (rst_n),
      .touch_key  (touch_key),
      .scan_key   (scan_key),
      .seg_S      (seg_S),
      .digit_sel  (digit_sel),
      .code       (code),
      .code_valid (code_valid),
      .code_ack   (code_ack)
   );

   always_comb begin
      touch_key = 4'b0000;
      for (int c = 0; c < 3; c++)
         if (scan_key[2-c]) touch_key = touch_key | {kp[c*4], kp[c*4+1], kp[c*4+2], kp[c*4+3]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [11:0] key_mask(input int k);
      int c, r;
      logic [11:0] m;
      if (k >= 1 && k <= 9) begin c = (k - 1) % 3; r = (k - 1) / 3; end
      else if (k == 0)      begin c = 1; r = 3; end
      else if (k == 10)     begin c = 0; r = 3; end
      else                  begin c = 2; r = 3; end
      m = '0;
      m[c*4+r] = 1'b1;
      return m;
   endfunction

   // Waits until n sweeps have completed (scan_key re-entering col1).
   task automatic sweeps(input int n);
      int seen = 0;
      int budget = 0;
      logic [2:0] prev;
      prev = scan_key;
      while (seen < n && budget < 40 * n + 40) begin
         @(negedge fin);
         budget++;
         if (scan_key == 3'b100 && prev != 3'b100) seen++;
         prev = scan_key;
      end
      if (seen < n) chk("sweep_timeout", seen, n);
   endtask

   task automatic press(input logic [11:0] m, input int on_s, input int off_s);
      sweeps(1);
      kp = m;
      sweeps(on_s);
      kp = '0;
      sweeps(off_s);
   endtask

   task automatic key(input int k);
      press(key_mask(k), 3, 3);
   endtask

   // d = {pos3, pos2, pos1, pos0}, pos0 rightmost.
   task automatic get_disp(output logic [27:0] d);
      logic [3:0] sel_exp;
      d = '0;
      repeat (2) @(negedge fin);
      for (int i = 0; i < 8; i++) begin
         @(negedge fin);
         for (int p = 0; p < 4; p++) begin
            sel_exp = ~(4'b0001 << p);
            if (digit_sel == sel_exp) d[p*7 +: 7] = seg_S;
         end
      end
   endtask

   initial begin
      logic [27:0] d;

      repeat (3) @(negedge fin);
      chk("rst_scan", scan_key, 3'b100);
      chk("rst_seg", seg_S, SB);
      chk("rst_sel", digit_sel, 4'b1110);
      chk("rst_code", code, 16'h0);
      chk("rst_valid", code_valid, 1'b0);
      rst_n = 1'b1;

      // Reset mid-sweep with '9' held
      kp = key_mask(9);
      repeat (17) @(negedge fin);
      #2 rst_n = 1'b0;
      @(negedge fin);
      chk("midrst_scan", scan_key, 3'b100);
      chk("midrst_seg", seg_S, SB);
      chk("midrst_valid", code_valid, 1'b0);
      chk("midrst_sel", digit_sel, 4'b1110);
      rst_n = 1'b1;
      sweeps(2);
      get_disp(d);
      chk("midrst_two_sweeps", d, {SB, SB, SB, SB});
      sweeps(1);
      kp = '0;
      sweeps(3);
      get_disp(d);
      chk("midrst_registered", d, {SB, SB, SB, S9});

      // Clear, then single '5'
      key(10);
      get_disp(d);
      chk("star_clear", d, {SB, SB, SB, SB});
      key(5);
      get_disp(d);
      chk("one_event_5", d, {SB, SB, SB, S5});

      // Bounce: 2 on, 1 off, 3 on gives one event; 2 on alone gives none
      sweeps(1);
      kp = key_mask(5); sweeps(2);
      kp = '0;          sweeps(1);
      kp = key_mask(5); sweeps(3);
      kp = '0;          sweeps(3);
      get_disp(d);
      chk("bounce_one_event", d, {SB, SB, S5, S5});
      press(key_mask(5), 2, 3);
      get_disp(d);
      chk("short_press_none", d, {SB, SB, S5, S5});

      // Full entry and commit
      key(10);
      key(1); key(2); key(3); key(4);
      get_disp(d);
      chk("entry_1234", d, {S1, S2, S3, S4});
      chk("entry_not_valid", code_valid, 1'b0);
      key(11);
      chk("commit_code", code, 16'h1234);
      chk("commit_valid", code_valid, 1'b1);
      key(7);
      chk("digit_while_valid_code", code, 16'h1234);
      get_disp(d);
      chk("digit_while_valid_disp", d, {S1, S2, S3, S4});
      key(10);
      chk("star_while_valid", code_valid, 1'b1);
      get_disp(d);
      chk("star_while_valid_disp", d, {S1, S2, S3, S4});
      code_ack = 1'b1;
      @(negedge fin);
      code_ack = 1'b0;
      chk("ack_valid", code_valid, 1'b0);
      chk("ack_code_kept", code, 16'h1234);
      get_disp(d);
      chk("ack_blank", d, {SB, SB, SB, SB});
      code_ack = 1'b1;
      @(negedge fin);
      code_ack = 1'b0;
      repeat (2) @(negedge fin);
      chk("idle_ack_ignored", code_valid, 1'b0);

      // '#' short entry, clear, illegal multi-key combos
      key(1); key(2); key(3);
      key(11);
      chk("hash_cnt3_valid", code_valid, 1'b0);
      chk("hash_cnt3_code", code, 16'h1234);
      get_disp(d);
      chk("hash_cnt3_disp", d, {SB, S1, S2, S3});
      key(10);
      get_disp(d);
      chk("star_blank", d, {SB, SB, SB, SB});
      press(key_mask(1) | key_mask(4), 3, 3);
      get_disp(d);
      chk("two_rows_none", d, {SB, SB, SB, SB});
      press(key_mask(1) | key_mask(2), 3, 3);
      get_disp(d);
      chk("two_cols_none", d, {SB, SB, SB, SB});
      key(2);
      get_disp(d);
      chk("after_combo_2", d, {SB, SB, SB, S2});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
